// File: rtl/acl_ssd_byte_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// acl_ssd_pkg
// Shared types for the accelerometer-to-PmodSSD byte sequencer.
//   t_seq_state : sequencer FSM states
//   t_nibble    : one hex digit driven to the SSD
//   t_byte      : one sample byte
//   t_bus       : widest possible sample (c_max_bytes bytes)
//   get_byte()  : select byte idx from a sample bus
// -----------------------------------------------------------------------------
package acl_ssd_pkg;

  localparam int c_max_bytes = 16;
  localparam int c_bus_w     = 8 * c_max_bytes;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_HOLD = 2'd2
  } t_seq_state;

  typedef logic [3:0]         t_nibble;
  typedef logic [7:0]         t_byte;
  typedef logic [c_bus_w-1:0] t_bus;

  function automatic t_byte get_byte(input t_bus data, input logic [3:0] idx);
    return data[8*idx +: 8];
  endfunction

endpackage

// File: rtl/acl_ssd_byte_sequencer_if.sv
// -----------------------------------------------------------------------------
// acl_ssd_byte_sequencer_if
// Valid/ready sample handshake between the accelerometer reader (master) and
// the byte sequencer (slave).
//   i_sample_valid : sample present (master -> slave)
//   i_sample_data  : byte k = [8k+7:8k] (master -> slave)
//   o_sample_ready : slave accepts this cycle (slave -> master)
// Signal names are written from the sequencer's point of view.
// -----------------------------------------------------------------------------
interface acl_ssd_byte_sequencer_if #(
  parameter int PAR_BYTE_COUNT = 8
);

  logic                        i_sample_valid;
  logic                        o_sample_ready;
  logic [8*PAR_BYTE_COUNT-1:0] i_sample_data;

  modport master (
    output i_sample_valid,
    output i_sample_data,
    input  o_sample_ready
  );

  modport slave (
    input  i_sample_valid,
    input  i_sample_data,
    output o_sample_ready
  );

endinterface

// File: rtl/acl_ssd_byte_sequencer_dwell_timer.sv
// -----------------------------------------------------------------------------
// dwell_timer
// Counts 0..PAR_DWELL_CYCLES-1 while enabled; o_terminal is high for the one
// enabled cycle at the last count, after which the counter restarts at 0.
//   i_clk, i_rst : clock, async active-high reset
//   i_en         : count enable (counter frozen when low)
//   i_clr        : synchronous clear, wins over i_en
//   o_terminal   : 1-cycle terminal-count pulse
// -----------------------------------------------------------------------------
module dwell_timer #(
  parameter int PAR_DWELL_CYCLES = 20_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_terminal
);

  localparam int             c_w    = $clog2(PAR_DWELL_CYCLES);
  localparam logic [c_w-1:0] c_last = c_w'(PAR_DWELL_CYCLES - 1);

  logic [c_w-1:0] count_q, count_d;

  assign o_terminal = i_en && (count_q == c_last);

  always_comb begin
    count_d = count_q;
    if (i_clr) begin
      count_d = '0;
    end else if (i_en) begin
      count_d = o_terminal ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/acl_ssd_byte_sequencer.sv
// -----------------------------------------------------------------------------
// acl_ssd_byte_sequencer
// Captures multi-byte accelerometer samples and presents them one byte at a
// time as two hex nibbles for the PmodSSD driver. A new sample is only shown
// once the current one has wrapped, so each displayed sample is coherent.
//   i_clk_20mhz, i_rst_20mhz : clock, async active-high reset
//   sample_if (slave)        : valid/ready sample handshake
//   i_hold                   : level, freeze displayed byte
//   i_step                   : pulse, advance one byte now
//   o_value0 / o_value1      : low / high nibble of the displayed byte
//   o_byte_index             : index of the displayed byte
//   o_overrun                : sticky, a pending sample was overwritten
//
// state   | meaning
// ST_IDLE | no sample received yet, outputs 0
// ST_SHOW | dwell timer running, advance on terminal count or i_step
// ST_HOLD | timer and index frozen, i_step ignored
// -----------------------------------------------------------------------------
module acl_ssd_byte_sequencer
  import acl_ssd_pkg::*;
#(
  parameter int PAR_BYTE_COUNT   = 8,
  parameter int PAR_DWELL_CYCLES = 20_000_000
) (
  input  logic                          i_clk_20mhz,
  input  logic                          i_rst_20mhz,
  acl_ssd_byte_sequencer_if.slave       sample_if,
  input  logic                          i_hold,
  input  logic                          i_step,
  output logic [3:0]                    o_value0,
  output logic [3:0]                    o_value1,
  output logic [3:0]                    o_byte_index,
  output logic                          o_overrun
);

  localparam int c_data_w = 8 * PAR_BYTE_COUNT;

  t_seq_state          state_q, state_d;
  logic [3:0]          idx_q, idx_d;
  logic [c_data_w-1:0] display_q, display_d;
  logic [c_data_w-1:0] pending_q, pending_d;
  logic                pending_full_q, pending_full_d;
  logic                overrun_q, overrun_d;
  logic                ready_q;
  t_nibble             value0_q, value1_q;
  logic [3:0]          index_out_q;

  logic  xfer, terminal, advance, at_last, load_pending, timer_clr;
  t_byte cur_byte;

  assign xfer         = sample_if.i_sample_valid && ready_q;
  assign at_last      = (idx_q == 4'(PAR_BYTE_COUNT - 1));
  assign advance      = (state_q == ST_SHOW) && (terminal || i_step);
  // The pending sample replaces the display only when the last byte wraps.
  assign load_pending = advance && at_last && pending_full_q;
  assign timer_clr    = advance || ((state_q == ST_IDLE) && xfer);

  dwell_timer #(
    .PAR_DWELL_CYCLES(PAR_DWELL_CYCLES)
  ) u_dwell_timer (
    .i_clk      (i_clk_20mhz),
    .i_rst      (i_rst_20mhz),
    .i_en       (state_q == ST_SHOW),
    .i_clr      (timer_clr),
    .o_terminal (terminal)
  );

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    display_d      = display_q;
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    overrun_d      = overrun_q;

    case (state_q)
      ST_IDLE: begin
        // First sample bypasses the pending buffer.
        if (xfer) begin
          display_d = sample_if.i_sample_data;
          idx_d     = '0;
          state_d   = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (advance) begin
          idx_d = at_last ? 4'd0 : idx_q + 4'd1;
        end
        if (i_hold) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!i_hold) begin
          state_d = ST_SHOW;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_pending) begin
      display_d      = pending_q;
      pending_full_d = 1'b0;
    end

    // A capture on the same cycle as the wrap refills the buffer just emptied,
    // so it does not count as an overrun.
    if (xfer && (state_q != ST_IDLE)) begin
      pending_d      = sample_if.i_sample_data;
      pending_full_d = 1'b1;
      if (pending_full_q && !load_pending) begin
        overrun_d = 1'b1;
      end
    end
  end

  assign cur_byte = get_byte(t_bus'(display_q), idx_q);

  always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
    if (i_rst_20mhz) begin
      state_q        <= ST_IDLE;
      idx_q          <= '0;
      display_q      <= '0;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      overrun_q      <= 1'b0;
      ready_q        <= 1'b0;
      value0_q       <= '0;
      value1_q       <= '0;
      index_out_q    <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      display_q      <= display_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      overrun_q      <= overrun_d;
      ready_q        <= 1'b1;
      value0_q       <= cur_byte[3:0];
      value1_q       <= cur_byte[7:4];
      index_out_q    <= idx_q;
    end
  end

  assign sample_if.o_sample_ready = ready_q;
  assign o_value0                 = value0_q;
  assign o_value1                 = value1_q;
  assign o_byte_index             = index_out_q;
  assign o_overrun                = overrun_q;

endmodule
